gate_actuator: RTL and testbench

GATE_ACTUATOR -- requirements
Module: gate_actuator

---
 rtl/gate_pkg.sv | 82 ++++++++
 rtl/sync2.sv | 33 +++
 rtl/gate_actuator.sv | 215 +++++++++++++++++++++
 tb/tb_gate_actuator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// -----------------------------------------------------------------------------
// gate_pkg
// Shared definitions for the level-crossing gate actuator: state encodings,
// default timing constants, the registered output bundle and the
// state-to-output decode used by the top level.
// -----------------------------------------------------------------------------
package gate_pkg;

  // State encodings are exported on the debug port, so keep them stable.
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_OPEN     = 3'd1,
    ST_WARN     = 3'd2,
    ST_LOWERING = 3'd3,
    ST_CLOSED   = 3'd4,
    ST_RAISING  = 3'd5,
    ST_BRAKE    = 3'd6,
    ST_FAULT    = 3'd7
  } gate_state_e;

  localparam int unsigned WARN_CYCLES_DEF  = 8;
  localparam int unsigned MOVE_TIMEOUT_DEF = 32;
  localparam int unsigned BRAKE_CYCLES_DEF = 2;
  localparam int unsigned INIT_CYCLES      = 3;
  localparam int unsigned TIMER_W          = 16;

  typedef struct packed {
    logic motor_up;
    logic motor_down;
    logic lamp;
    logic bell;
    logic gate_closed;
    logic gate_is_open;
    logic fault;
  } gate_out_t;

  // Moore decode: every output is a pure function of the state. The motor
  // drives are each tied to exactly one state, so they can never be on
  // together.
  function automatic gate_out_t decode_outputs(input gate_state_e st);
    gate_out_t o;
    o = '0;
    case (st)
      ST_INIT: begin
        o = '0;
      end
      ST_OPEN: begin
        o.gate_is_open = 1'b1;
      end
      ST_WARN: begin
        o.lamp = 1'b1;
        o.bell = 1'b1;
      end
      ST_LOWERING: begin
        o.motor_down = 1'b1;
        o.lamp       = 1'b1;
        o.bell       = 1'b1;
      end
      ST_CLOSED: begin
        o.lamp        = 1'b1;
        o.gate_closed = 1'b1;
      end
      ST_RAISING: begin
        o.motor_up = 1'b1;
        o.lamp     = 1'b1;
      end
      ST_BRAKE: begin
        o.lamp = 1'b1;
      end
      ST_FAULT: begin
        o.lamp  = 1'b1;
        o.bell  = 1'b1;
        o.fault = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for an asynchronous level input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (clears both stages)
//   d     - asynchronous input
//   q     - synchronized output, two clock cycles of latency
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back stages; meta_q may go metastable and is never used elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gate_actuator.sv
// -----------------------------------------------------------------------------
// gate_actuator
// Level-crossing barrier controller: warns road traffic, drives the barrier
// motor up/down, inserts a motor-off dead time on direction reversal and
// latches a fault on move timeout or contradictory limit switches.
// Ports:
//   Clk          - single clock, rising edge
//   Reset_n      - asynchronous active-low reset
//   gate_open    - controller request, 1 = open, 0 = close (synchronous)
//   lim_up       - upper limit switch (asynchronous), 1 = fully raised
//   lim_down     - lower limit switch (asynchronous), 1 = fully lowered
//   fault_clr    - single-cycle fault acknowledge
//   motor_up     - raise drive
//   motor_down   - lower drive
//   lamp, bell   - road warning outputs
//   gate_closed  - status, 1 only in CLOSED
//   gate_is_open - status, 1 only in OPEN
//   fault        - 1 only in FAULT
//   state        - current state encoding for debug
// -----------------------------------------------------------------------------
module gate_actuator
  import gate_pkg::*;
#(
  parameter int unsigned WARN_CYCLES  = WARN_CYCLES_DEF,
  parameter int unsigned MOVE_TIMEOUT = MOVE_TIMEOUT_DEF,
  parameter int unsigned BRAKE_CYCLES = BRAKE_CYCLES_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       gate_open,
  input  logic       lim_up,
  input  logic       lim_down,
  input  logic       fault_clr,
  output logic       motor_up,
  output logic       motor_down,
  output logic       lamp,
  output logic       bell,
  output logic       gate_closed,
  output logic       gate_is_open,
  output logic       fault,
  output logic [2:0] state
);

  // The timer holds the number of cycles already spent in the current state,
  // so a state that must last N cycles is left once the timer reaches N-1.
  localparam logic [TIMER_W-1:0] INIT_LAST  = TIMER_W'(INIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WARN_LAST  = TIMER_W'(WARN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MOVE_LAST  = TIMER_W'(MOVE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BRAKE_LAST = TIMER_W'(BRAKE_CYCLES - 1);

  logic               lim_up_s;
  logic               lim_down_s;
  logic               both_lim_s;
  gate_state_e        state_q;
  gate_state_e        state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  gate_out_t          out_q;
  gate_out_t          out_d;

  sync2 u_sync_up (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (lim_up),
    .q     (lim_up_s)
  );

  sync2 u_sync_down (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (lim_down),
    .q     (lim_down_s)
  );

  assign both_lim_s = lim_up_s & lim_down_s;

  // Next-state logic; contradictory limits override every other transition.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_INIT) && both_lim_s) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (timer_q >= INIT_LAST) begin
            if (lim_down_s) begin
              state_d = ST_CLOSED;
            end else if (lim_up_s) begin
              state_d = ST_OPEN;
            end else if (gate_open) begin
              state_d = ST_RAISING;
            end else begin
              state_d = ST_WARN;
            end
          end else begin
            state_d = ST_INIT;
          end
        end
        ST_OPEN: begin
          if (!gate_open) begin
            state_d = ST_WARN;
          end else begin
            state_d = ST_OPEN;
          end
        end
        ST_WARN: begin
          if (gate_open) begin
            state_d = ST_OPEN;
          end else if (timer_q >= WARN_LAST) begin
            state_d = ST_LOWERING;
          end else begin
            state_d = ST_WARN;
          end
        end
        ST_LOWERING: begin
          if (lim_down_s) begin
            state_d = ST_CLOSED;
          end else if (gate_open) begin
            state_d = ST_BRAKE;
          end else if (timer_q >= MOVE_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_LOWERING;
          end
        end
        ST_CLOSED: begin
          if (gate_open) begin
            state_d = ST_RAISING;
          end else begin
            state_d = ST_CLOSED;
          end
        end
        ST_RAISING: begin
          if (lim_up_s) begin
            state_d = ST_OPEN;
          end else if (!gate_open) begin
            state_d = ST_BRAKE;
          end else if (timer_q >= MOVE_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_RAISING;
          end
        end
        ST_BRAKE: begin
          // Direction is taken from the request as it stands at exit, so a
          // request that flips back during the dead time is honoured.
          if (timer_q >= BRAKE_LAST) begin
            if (gate_open) begin
              state_d = ST_RAISING;
            end else begin
              state_d = ST_LOWERING;
            end
          end else begin
            state_d = ST_BRAKE;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            if (gate_open) begin
              state_d = ST_RAISING;
            end else begin
              state_d = ST_LOWERING;
            end
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end
  end

  // Cycle timer: cleared on any state change, otherwise counts and saturates.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == {TIMER_W{1'b1}}) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Outputs are decoded from the next state so the registered copy lines up
  // with state_q in the same cycle.
  always_comb begin
    out_d = decode_outputs(state_d);
  end

  // State, timer and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      timer_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      out_q   <= out_d;
    end
  end

  assign motor_up     = out_q.motor_up;
  assign motor_down   = out_q.motor_down;
  assign lamp         = out_q.lamp;
  assign bell         = out_q.bell;
  assign gate_closed  = out_q.gate_closed;
  assign gate_is_open = out_q.gate_is_open;
  assign fault        = out_q.fault;
  assign state        = state_q;

endmodule

// File: tb/tb_gate_actuator.sv
// -----------------------------------------------------------------------------
// tb_gate_actuator
// Directed bench for gate_actuator with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_gate_actuator;

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_OPEN     = 3'd1;
  localparam logic [2:0] S_WARN     = 3'd2;
  localparam logic [2:0] S_LOWERING = 3'd3;
  localparam logic [2:0] S_CLOSED   = 3'd4;
  localparam logic [2:0] S_RAISING  = 3'd5;
  localparam logic [2:0] S_BRAKE    = 3'd6;
  localparam logic [2:0] S_FAULT    = 3'd7;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       gate_open;
  logic       lim_up;
  logic       lim_down;
  logic       fault_clr;
  logic       motor_up;
  logic       motor_down;
  logic       lamp;
  logic       bell;
  logic       gate_closed;
  logic       gate_is_open;
  logic       fault;
  logic [2:0] state;
  logic [9:0] obs_vec;

  int n_checks = 0;
  int n_fail   = 0;

  gate_actuator dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .gate_open    (gate_open),
    .lim_up       (lim_up),
    .lim_down     (lim_down),
    .fault_clr    (fault_clr),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .lamp         (lamp),
    .bell         (bell),
    .gate_closed  (gate_closed),
    .gate_is_open (gate_is_open),
    .fault        (fault),
    .state        (state)
  );

  always #5 Clk = ~Clk;

  assign obs_vec = {state, motor_up, motor_down, lamp, bell, gate_closed, gate_is_open, fault};

  // Expected {state, motor_up, motor_down, lamp, bell, gate_closed, gate_is_open, fault}.
  function automatic logic [9:0] model(input logic [2:0] st);
    logic mu, md, lp, bl, gc, go, fl;
    mu = (st == S_RAISING);
    md = (st == S_LOWERING);
    lp = !((st == S_INIT) || (st == S_OPEN));
    bl = (st == S_WARN) || (st == S_LOWERING) || (st == S_FAULT);
    gc = (st == S_CLOSED);
    go = (st == S_OPEN);
    fl = (st == S_FAULT);
    return {st, mu, md, lp, bl, gc, go, fl};
  endfunction

  task automatic expect_st(input string tag, input logic [2:0] st);
    logic [9:0] exp_vec;
    exp_vec = model(st);
    n_checks++;
    assert (obs_vec === exp_vec) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs_vec, exp_vec);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Reset_n   = 1'b0;
    gate_open = 1'b1;
    lim_up    = 1'b1;
    lim_down  = 1'b0;
    fault_clr = 1'b0;
    cyc(2);
    expect_st("reset", S_INIT);

    // Power-up with the barrier already raised.
    Reset_n = 1'b1;
    cyc(1);
    expect_st("init_c1", S_INIT);
    cyc(1);
    expect_st("init_c2", S_INIT);
    cyc(1);
    expect_st("init_to_open", S_OPEN);

    // Close request: 8 warning cycles, then lowering.
    gate_open = 1'b0;
    lim_up    = 1'b0;
    cyc(1);
    expect_st("warn_first", S_WARN);
    cyc(7);
    expect_st("warn_last", S_WARN);
    cyc(1);
    expect_st("lowering_entry", S_LOWERING);
    cyc(9);
    expect_st("lowering_10", S_LOWERING);
    lim_down = 1'b1;
    cyc(2);
    expect_st("lowering_sync", S_LOWERING);
    cyc(1);
    expect_st("closed", S_CLOSED);

    // Raise, reverse to lower through BRAKE, reverse again to raise.
    gate_open = 1'b1;
    lim_down  = 1'b0;
    cyc(1);
    expect_st("raising", S_RAISING);
    gate_open = 1'b0;
    cyc(1);
    expect_st("brake_dn_1", S_BRAKE);
    cyc(1);
    expect_st("brake_dn_2", S_BRAKE);
    cyc(1);
    expect_st("brake_to_lower", S_LOWERING);
    gate_open = 1'b1;
    cyc(1);
    expect_st("brake_up_1", S_BRAKE);
    cyc(1);
    expect_st("brake_up_2", S_BRAKE);
    cyc(1);
    expect_st("brake_to_raise", S_RAISING);
    lim_up = 1'b1;
    cyc(2);
    expect_st("raising_sync", S_RAISING);
    cyc(1);
    expect_st("raised_open", S_OPEN);

    // Lowering timeout: lim_down never arrives.
    gate_open = 1'b0;
    lim_up    = 1'b0;
    cyc(1);
    expect_st("to_warn2", S_WARN);
    cyc(8);
    expect_st("to_lower2", S_LOWERING);
    cyc(31);
    expect_st("lower_last", S_LOWERING);
    cyc(1);
    expect_st("timeout_fault", S_FAULT);
    cyc(1);
    expect_st("fault_hold", S_FAULT);
    gate_open = 1'b1;
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    expect_st("clr_to_raise", S_RAISING);

    // Reverse into a zero-motion lower (limit already active), then both limits.
    gate_open = 1'b0;
    lim_down  = 1'b1;
    cyc(1);
    expect_st("brake_b1", S_BRAKE);
    cyc(1);
    expect_st("brake_b2", S_BRAKE);
    cyc(1);
    expect_st("zero_move_lower", S_LOWERING);
    cyc(1);
    expect_st("zero_move_closed", S_CLOSED);
    lim_up = 1'b1;
    cyc(2);
    expect_st("both_sync", S_CLOSED);
    cyc(1);
    expect_st("both_fault", S_FAULT);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    expect_st("clr_ignored", S_FAULT);
    lim_up = 1'b0;
    cyc(2);
    expect_st("released_hold", S_FAULT);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    expect_st("clr_to_lower", S_LOWERING);
    cyc(1);
    expect_st("lower_done", S_CLOSED);

    // Reset during RAISING must act without a clock edge.
    gate_open = 1'b1;
    lim_down  = 1'b0;
    cyc(1);
    expect_st("raise_pre_rst", S_RAISING);
    #2;
    Reset_n = 1'b0;
    #1;
    expect_st("async_reset", S_INIT);
    cyc(1);
    expect_st("reset_hold", S_INIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
